// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM state encoding, BCD constants and the digit type.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef logic [3:0] digit_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder slice with decimal correction.
// With BCD_CHECK_EN defined, it also flags operand digits above nine.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    input  logic   ci,
    output digit_t s,
`ifdef BCD_CHECK_EN
    output logic   bad,
`endif
    output logic   co
);

    logic [4:0] z;

    // A binary sum above nine wraps past the six unused codes to land back on a decimal digit
    always_comb begin
        z  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        s  = z[3:0];
        co = 1'b0;
        if (z > {1'b0, BCD_MAX}) begin
            s  = z[3:0] + BCD_ADJ;
            co = 1'b1;
        end
    end

`ifdef BCD_CHECK_EN
    assign bad = (a > BCD_MAX) || (b > BCD_MAX);
`endif

endmodule

// File: rtl/serial_bcd_adder.sv
// N-digit BCD adder that reuses one digit slice, least-significant digit first, one digit per clock.
// Optional invalid-digit detection is built when BCD_CHECK_EN is defined.
module serial_bcd_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  error
);

    state_t              state;
    state_t              nextState;
    logic [CNT_W-1:0]    digitIdx;
    logic                carryReg;
    logic [4*DIGITS-1:0] latchA;
    logic [4*DIGITS-1:0] latchB;
    digit_t              curA;
    digit_t              curB;
    digit_t              digitSum;
    logic                digitCarry;
    logic                lastDigit;
    logic                accept;

    assign curA      = latchA[4*digitIdx +: 4];
    assign curB      = latchB[4*digitIdx +: 4];
    assign lastDigit = (digitIdx == CNT_W'(DIGITS - 1));

`ifdef BCD_CHECK_EN
    logic digitBad;

    bcd_digit_add u_digit (
        .a   (curA),
        .b   (curB),
        .ci  (carryReg),
        .s   (digitSum),
        .bad (digitBad),
        .co  (digitCarry)
    );
`else
    bcd_digit_add u_digit (
        .a   (curA),
        .b   (curB),
        .ci  (carryReg),
        .s   (digitSum),
        .co  (digitCarry)
    );

    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Start is only honoured from IDLE, so requests during ADD or DONE are simply dropped
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    nextState = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (lastDigit) nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Operands are captured on accept so the caller may change them while the digits are worked through
    always_ff @(posedge clk) begin
        if (rst) begin
            latchA   <= '0;
            latchB   <= '0;
            carryReg <= 1'b0;
            digitIdx <= '0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef BCD_CHECK_EN
            error    <= 1'b0;
`endif
        end else if (accept) begin
            latchA   <= a;
            latchB   <= b;
            carryReg <= cin;
            digitIdx <= '0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef BCD_CHECK_EN
            error    <= 1'b0;
`endif
        end else if (state == ADD) begin
            sum[4*digitIdx +: 4] <= digitSum;
            carryReg             <= digitCarry;
            if (lastDigit) cout <= digitCarry;
            else           digitIdx <= digitIdx + 1'b1;
`ifdef BCD_CHECK_EN
            if (digitBad) error <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_serial_bcd_adder.sv
// Self-checking bench for serial_bcd_adder: a decimal-arithmetic reference model with a per-cycle
// compare process, plus directed vectors with hand-computed results. Honours BCD_CHECK_EN.
module tb_serial_bcd_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         error;

    int compared   = 0;
    int mismatched = 0;
    int cycleNo    = 0;

    always #5 clk = ~clk;

    serial_bcd_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .error (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    // Reference: treat operands as decimal numbers and add them as integers
    function automatic void bcdModel(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                     output logic [W-1:0] s, output logic co, output logic bad);
        longint dx;
        longint dy;
        longint lim;
        longint total;
        dx  = 0;
        dy  = 0;
        lim = 1;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dx  += longint'(x[4*i +: 4]) * lim;
            dy  += longint'(y[4*i +: 4]) * lim;
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
            lim *= 10;
        end
        total = dx + dy + longint'(c);
        co    = (total >= lim);
        total = total % lim;
        s     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s[4*i +: 4] = 4'(total % 10);
            total       = total / 10;
        end
    endfunction

    // Timeline model: 0 = idle, 1..DIGITS = adding, DIGITS+1 = result cycle
    int           expCycle = 0;
    logic [W-1:0] pendSum  = '0;
    logic         pendCout = 1'b0;
    logic         pendBad  = 1'b0;
    logic [W-1:0] visSum   = '0;
    logic         visCout  = 1'b0;
    logic         visErr   = 1'b0;

    always @(posedge clk) begin
        cycleNo++;
        if (rst) begin
            expCycle = 0;
            visSum   = '0;
            visCout  = 1'b0;
            visErr   = 1'b0;
        end else if (expCycle == 0) begin
            if (start) begin
                bcdModel(a, b, cin, pendSum, pendCout, pendBad);
                visSum   = '0;
                visCout  = 1'b0;
                visErr   = 1'b0;
                expCycle = 1;
            end
        end else if (expCycle <= DIGITS) begin
            expCycle++;
            if (expCycle == DIGITS + 1) begin
                visSum  = pendSum;
                visCout = pendCout;
`ifdef BCD_CHECK_EN
                visErr  = pendBad;
`else
                visErr  = 1'b0;
`endif
            end
        end else begin
            expCycle = 0;
        end
    end

    always @(negedge clk) begin
        if (cycleNo > 0) begin
            checkOutput("busy", busy, (expCycle >= 1 && expCycle <= DIGITS));
            checkOutput("done", done, (expCycle == DIGITS + 1));
            if (expCycle == 0 || expCycle == DIGITS + 1) begin
                checkOutput("sum", sum, visSum);
                checkOutput("cout", cout, visCout);
                checkOutput("error", error, visErr);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runAdd(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W-1:0] expSum, input logic expCout);
        int lat;
        int busyCnt;
        applyStimulus(x, y, c);
        waitDone(lat, busyCnt);
        checkOutput({name, "_latency"}, lat, DIGITS + 1);
        checkOutput({name, "_sum"}, sum, expSum);
        checkOutput({name, "_cout"}, cout, expCout);
    endtask

    initial begin
        int lat;
        int busyCnt;
        int doneCnt;
        int doneAt[$];

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_error", error, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(16'h1234, 16'h5678, 1'b0);
        waitDone(lat, busyCnt);
        checkOutput("t1_latency", lat, 5);
        checkOutput("t1_busy_cycles", busyCnt, 4);
        checkOutput("t1_sum", sum, 16'h6912);
        checkOutput("t1_cout", cout, 0);

        runAdd("t2a", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1);
        runAdd("t2b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        runAdd("t2c", 16'h4567, 16'h5678, 1'b1, 16'h0246, 1'b1);

        applyStimulus(16'h0500, 16'h0500, 1'b0);
        @(posedge clk);
        #1;
        a     = 16'h1111;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        doneCnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        @(posedge clk);
        #1;
        checkOutput("t3_done_pulses", doneCnt, 1);
        checkOutput("t3_sum", sum, 16'h1000);
        checkOutput("t3_cout", cout, 0);

        applyStimulus(16'h9999, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_sum", sum, 16'h0000);
        checkOutput("t4_cout", cout, 0);
        doneCnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        @(posedge clk);
        #1;
        checkOutput("t4_no_done", doneCnt, 0);
        runAdd("t4_restart", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1);

        runAdd("t5_bad", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0);
`ifdef BCD_CHECK_EN
        checkOutput("t5_error_set", error, 1);
`else
        checkOutput("t5_error_set", error, 0);
`endif
        runAdd("t5_good", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        checkOutput("t5_error_clear", error, 0);

        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 60 && doneAt.size() < 3; k++) begin
            @(negedge clk);
            if (done) begin
                doneAt.push_back(cycleNo);
                checkOutput("t6_sum", sum, 16'h0002);
            end
        end
        start = 1'b0;
        checkOutput("t6_done_count", doneAt.size(), 3);
        if (doneAt.size() == 3) begin
            checkOutput("t6_period1", doneAt[1] - doneAt[0], DIGITS + 2);
            checkOutput("t6_period2", doneAt[2] - doneAt[1], DIGITS + 2);
        end
        repeat (10) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
